// File: rtl/mult_div_unit.sv
// Shared iterative multiply/divide engine.
// Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle.
// Divide: restoring shift-subtract, one quotient bit per cycle.
// Signs are recorded at start and applied once in the FINISH state.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Two's-complement negation of an operand-width value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;   // product / quotient negative
  logic                 neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic                 dz_pend_q, dz_pend_d;   // divide-by-zero pending in FINISH
  logic [WIDTH-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;           // mult: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 signed_op_s;
  logic                 sign_a_s;
  logic                 sign_b_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     quot_s;

  // Operand magnitudes and per-iteration datapath arithmetic.
  always_comb begin
    signed_op_s = ~op[0];
    sign_a_s    = signed_op_s & a[WIDTH-1];
    sign_b_s    = signed_op_s & b[WIDTH-1];
    mag_a_s     = sign_a_s ? neg_w(a) : a;
    mag_b_s     = sign_b_s ? neg_w(b) : b;
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    rem_s       = acc_q[2*WIDTH-1:WIDTH];
    quot_s      = acc_q[WIDTH-1:0];
  end

  // Next-state and output logic of the start/run/finish sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = sign_a_s ^ sign_b_s;
          neg_rem_d = sign_a_s;
          cnt_d     = {CW{1'b0}};
          busy_d    = 1'b1;
          if (op[1]) begin
            opnd_d = mag_b_s;
            acc_d  = {{WIDTH{1'b0}}, mag_a_s};
          end else begin
            opnd_d = mag_a_s;
            acc_d  = {{WIDTH{1'b0}}, mag_b_s};
          end
          if (op[1] && (b == {WIDTH{1'b0}})) begin
            dz_pend_d = 1'b1;
            state_d   = ST_FINISH;
          end else begin
            dz_pend_d = 1'b0;
            state_d   = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (is_div_q) begin
          if (div_diff_s[WIDTH]) begin
            acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_pend_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = neg_rem_q ? neg_w(rem_s) : rem_s;
          lo_d = neg_res_q ? neg_w(quot_s) : quot_s;
        end else begin
          {hi_d, lo_d} = neg_res_q ? neg_2w(acc_q) : acc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      opnd_q     <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_pend_q  <= dz_pend_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: one 32-bit and one 8-bit instance.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = 32'h0;
  logic [31:0] b32 = 32'h0;
  logic [31:0] hi32, lo32;
  logic        busy32, done32, dz32;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = 8'h0;
  logic [7:0]  b8 = 8'h0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dz8;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive start for one edge, then scramble inputs.
  task automatic go(input bit w8, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (w8) begin
      start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    end
    @(negedge clock);
    start8 = 1'b0;
    start32 = 1'b0;
    if (w8) begin
      op8 = ~o; a8 = ~x[7:0]; b8 = ~y[7:0];
    end else begin
      op32 = ~o; a32 = ~x; b32 = ~y;
    end
  endtask

  task automatic wait_done(input bit w8, output int lat);
    lat = 0;
    while (((w8 ? done8 : done32) !== 1'b1) && (lat < 200)) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Full 32-bit operation: start, wait, check latency and result.
  task automatic op_32(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    go(1'b0, o, x, y);
    wait_done(1'b0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, 64'(hi32), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo32), 64'(elo));
    chk({tag, "_dz"}, 64'(dz32), 64'd0);
  endtask

  initial begin
    int lat;
    int ndone;

    // Reset state.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_dz", 64'(dz32), 64'd0);
    chk("rst8_busy", 64'(busy8), 64'd0);

    // MULT -3*5 with an ignored start pulse mid-operation.
    go(1'b0, MULT, 32'hFFFFFFFD, 32'd5);
    chk("m1_busy0", 64'(busy32), 64'd1);
    repeat (5) @(negedge clock);
    start32 = 1'b1; op32 = MULTU; a32 = 32'd7; b32 = 32'd7;
    @(negedge clock);
    start32 = 1'b0;
    wait_done(1'b0, lat);
    chk("m1_lat", 64'(lat + 6), 64'd33);
    chk("m1_hi", 64'(hi32), 64'hFFFFFFFF);
    chk("m1_lo", 64'(lo32), 64'hFFFFFFF1);
    chk("m1_busy_done", 64'(busy32), 64'd0);
    @(negedge clock);
    chk("m1_done_drop", 64'(done32), 64'd0);
    chk("m1_hold_lo", 64'(lo32), 64'hFFFFFFF1);

    op_32("mu2", MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    op_32("m2", MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_32("d1", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_32("du1", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    op_32("dovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    op_32("d2", DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);

    // Divide by zero keeps hi/lo.
    op_32("pre", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    go(1'b0, DIVU, 32'd9, 32'd0);
    wait_done(1'b0, lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_flag", 64'(dz32), 64'd1);
    chk("dz_hi", 64'(hi32), 64'd0);
    chk("dz_lo", 64'(lo32), 64'd42);
    chk("dz_busy", 64'(busy32), 64'd0);
    @(negedge clock);
    chk("dz_drop", 64'(dz32), 64'd0);
    chk("dz_done_drop", 64'(done32), 64'd0);

    // Reset mid-operation aborts with no done.
    go(1'b0, MULTU, 32'd100, 32'd100);
    repeat (5) @(negedge clock);
    start32 = 1'b1; op32 = MULTU; a32 = 32'd3; b32 = 32'd3;
    @(negedge clock);
    start32 = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("ra_busy", 64'(busy32), 64'd0);
    chk("ra_hi", 64'(hi32), 64'd0);
    chk("ra_lo", 64'(lo32), 64'd0);
    chk("ra_done", 64'(done32), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done32 === 1'b1) ndone++;
    end
    chk("ra_nodone", 64'(ndone), 64'd0);
    op_32("fresh", MULTU, 32'd100, 32'd100, 32'd0, 32'd10000);

    // WIDTH=8: signed divide, then back-to-back multiply in the done cycle.
    go(1'b1, DIV, 32'h81, 32'h04);
    wait_done(1'b1, lat);
    chk("w8d_lat", 64'(lat), 64'd9);
    chk("w8d_lo", 64'(lo8), 64'hE1);
    chk("w8d_hi", 64'(hi8), 64'hFD);
    go(1'b1, MULTU, 32'hFF, 32'hFF);
    chk("w8m_busy0", 64'(busy8), 64'd1);
    chk("w8m_done0", 64'(done8), 64'd0);
    wait_done(1'b1, lat);
    chk("w8m_lat", 64'(lat), 64'd9);
    chk("w8m_hi", 64'(hi8), 64'hFE);
    chk("w8m_lo", 64'(lo8), 64'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
